risc_control_core: RTL

- Multi-cycle fetch/decode/execute core for the 10-bit MCU.
- Sits directly upstream of the unified 256x10 program/data memory. It drives that memory's address, write strobe and write data, and consumes its combinational read data.
- Holds PC, IR, four 8-bit registers R0..R3 and the zero flag; executes the 10-bit ISA below.

---
 rtl/risc_control_core_pkg.sv | 59 +++++
 rtl/risc_alu.sv | 25 ++
 rtl/risc_control_core.sv | 135 +++++++++++++
 3 files changed

// File: rtl/risc_control_core_pkg.sv
// rtl/risc_control_core_pkg.sv - shared ISA constants, FSM encoding and decode helper for the MCU core
package risc_control_core_pkg;

    localparam int WORD_SIZE    = 10;
    localparam int ADDRESS_SIZE = 8;
    localparam int REG_WIDTH    = 8;
    localparam int NUM_REGS     = 4;

    // Instruction field positions
    localparam int OPC_MSB  = 9;
    localparam int RS1_LSB  = 4;
    localparam int RS2_LSB  = 2;
    localparam int RD_LSB   = 0;
    localparam int REG_SEL_W = 2;
    localparam int TARGET_W = 7;
    localparam int IMM_W    = 8;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_NOT   = 4'b0100;
    localparam logic [4:0] OP_SIZ   = 5'b01010;
    localparam logic [4:0] OP_NOP   = 5'b01011;
    localparam logic [2:0] OP_JUMP  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [1:0] OP_SAVE  = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_ALU   = 3'd0,
        C_SIZ   = 3'd1,
        C_NOP   = 3'd2,
        C_JUMP  = 3'd3,
        C_STORE = 3'd4,
        C_LOAD  = 3'd5,
        C_SAVE  = 3'd6
    } iclass_t;

    // Every 10-bit pattern maps to some class; the ALU class absorbs [9:6]=0000..0100.
    function automatic iclass_t decode_class(input logic [WORD_SIZE-1:0] ir);
        iclass_t cls;
        if (ir[9:8] == OP_SAVE)       cls = C_SAVE;
        else if (ir[9:7] == OP_LOAD)  cls = C_LOAD;
        else if (ir[9:7] == OP_STORE) cls = C_STORE;
        else if (ir[9:7] == OP_JUMP)  cls = C_JUMP;
        else if (ir[9:5] == OP_SIZ)   cls = C_SIZ;
        else if (ir[9:5] == OP_NOP)   cls = C_NOP;
        else                          cls = C_ALU;
        return cls;
    endfunction

endpackage

// File: rtl/risc_alu.sv
// rtl/risc_alu.sv - combinational ALU: ADD/SUB/AND/OR/NOT with zero detect
module risc_alu
    import risc_control_core_pkg::*;
#(
    parameter int width = REG_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] result,
    output logic             zero
);

    always_comb begin
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = ~a;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/risc_control_core.sv
// rtl/risc_control_core.sv - multi-cycle fetch/execute/memory core driving a unified 256x10 memory
module risc_control_core
    import risc_control_core_pkg::*;
#(
    parameter int word_size    = WORD_SIZE,
    parameter int address_size = ADDRESS_SIZE,
    parameter int reg_width    = REG_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    output logic [address_size-1:0] mem_address,
    output logic [word_size-1:0]    mem_wdata,
    output logic                    mem_write,
    input  logic [word_size-1:0]    mem_rdata,
    output logic [address_size-1:0] pc_out,
    output logic [reg_width-1:0]    r0_out,
    output logic                    zero_out,
    output logic                    retire
);

    state_t                  state_q, state_d;
    logic [address_size-1:0] pc_q, pc_d;
    logic [word_size-1:0]    ir_q, ir_d;
    logic [reg_width-1:0]    regs_q [NUM_REGS];
    logic [reg_width-1:0]    regs_d [NUM_REGS];
    logic                    zero_q, zero_d;
    logic                    mem_write_q, mem_write_d;
    logic                    retire_q, retire_d;

    logic [address_size-1:0] pc_inc1, pc_inc2, mem_target;
    iclass_t                 cur_class, fetch_class;
    logic [reg_width-1:0]    alu_a, alu_b, alu_result;
    logic                    alu_zero;

    assign pc_inc1     = pc_q + address_size'(1);
    assign pc_inc2     = pc_q + address_size'(2);
    assign mem_target  = address_size'(ir_q[TARGET_W-1:0]);
    assign cur_class   = decode_class(ir_q);
    assign fetch_class = decode_class(mem_rdata);

    assign alu_a = regs_q[ir_q[RS1_LSB +: REG_SEL_W]];
    assign alu_b = regs_q[ir_q[RS2_LSB +: REG_SEL_W]];

    risc_alu #(
        .width (reg_width)
    ) u_alu (
        .op     (ir_q[OPC_MSB -: 4]),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Memory-facing outputs depend only on registered state, never on mem_rdata.
    assign mem_address = (state_q == S_MEM) ? mem_target : pc_q;
    assign mem_wdata   = {{(word_size-reg_width){1'b0}}, regs_q[0]};
    assign mem_write   = mem_write_q;
    assign retire      = retire_q;
    assign pc_out      = pc_q;
    assign r0_out      = regs_q[0];
    assign zero_out    = zero_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        zero_d      = zero_q;
        mem_write_d = 1'b0;
        retire_d    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ir_d     = mem_rdata;
                    state_d  = S_EXEC;
                    // Two-cycle instructions retire in EXEC, so the pulse is armed now.
                    retire_d = (fetch_class != C_LOAD) && (fetch_class != C_STORE);
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc1;
                case (cur_class)
                    C_ALU: begin
                        regs_d[ir_q[RD_LSB +: REG_SEL_W]] = alu_result;
                        zero_d = alu_zero;
                    end
                    C_SAVE:  regs_d[0] = ir_q[IMM_W-1:0];
                    C_SIZ:   pc_d = zero_q ? pc_inc2 : pc_inc1;
                    C_JUMP:  pc_d = mem_target;
                    C_LOAD, C_STORE: begin
                        state_d     = S_MEM;
                        pc_d        = pc_q;
                        retire_d    = 1'b1;
                        mem_write_d = (cur_class == C_STORE);
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (cur_class == C_LOAD) begin
                    regs_d[0] = mem_rdata[reg_width-1:0];
                end
                pc_d    = pc_inc1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            zero_q      <= 1'b0;
            mem_write_q <= 1'b0;
            retire_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            zero_q      <= zero_d;
            mem_write_q <= mem_write_d;
            retire_q    <= retire_d;
            regs_q      <= regs_d;
        end
    end

endmodule
